// File: rtl/dft_pkg.sv
// Shared types and default widths for the DFT sample load / compute datapath.
// Imported by the cache loader, the control FSM and the compute cache.
package dft_pkg;

  localparam int DFT_ADDR_W = 12;
  localparam int DFT_DATA_W = 16;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_READ,
    LD_DRAIN,
    LD_DONE
  } ld_state_t;

endpackage

// File: rtl/sample_cache_loader_rd_lat_pipe.sv
// Valid+address delay line matching the sample RAM read latency, so each
// returning data word is paired with the address that requested it.
module rd_lat_pipe
  import dft_pkg::*;
#(
  parameter int ADDR_W = DFT_ADDR_W,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_adr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_adr,
  output logic              inner_busy
);

  logic              valid_reg [DEPTH];
  logic [ADDR_W-1:0] adr_reg   [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              stage_valid;
      logic [ADDR_W-1:0] stage_adr;

      if (gi == 0) begin : g_head
        assign stage_valid = in_valid;
        assign stage_adr   = in_adr;
      end else begin : g_tail
        assign stage_valid = valid_reg[gi-1];
        assign stage_adr   = adr_reg[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          adr_reg[gi]   <= '0;
        end else if (ce) begin
          valid_reg[gi] <= stage_valid;
          adr_reg[gi]   <= stage_adr;
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg[DEPTH-1];
  assign out_adr   = adr_reg[DEPTH-1];

  // Everything except the output stage: once these are empty the pipe drains
  // on the next enabled edge, which lets the done pulse follow the last write.
  always_comb begin
    inner_busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inner_busy = inner_busy | valid_reg[i];
    end
  end

endmodule

// File: rtl/sample_cache_loader.sv
// Copies sample_num words from the sample RAM (addresses 0..N-1) into the
// compute cache at one word per enabled cycle, then pulses data_to_cache_loaded.
module sample_cache_loader
  import dft_pkg::*;
#(
  parameter int ADDR_W = DFT_ADDR_W,
  parameter int DATA_W = DFT_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] sample_num,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_adr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              cache_wr_en,
  output logic [ADDR_W-1:0] cache_wr_adr,
  output logic [DATA_W-1:0] cache_wr_data,
  output logic              busy,
  output logic              data_to_cache_loaded
);

  ld_state_t         state_reg;
  logic [ADDR_W-1:0] n_reg;
  logic [ADDR_W-1:0] rd_cnt_reg;
  logic              rd_en_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_adr;
  logic              pipe_inner_busy;
  logic [ADDR_W-1:0] last_adr;

  // Terminal compare on N-1 keeps N = 2^ADDR_W-1 from wrapping the counter.
  assign last_adr = n_reg - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= LD_IDLE;
      n_reg      <= '0;
      rd_cnt_reg <= '0;
      rd_en_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (ce) begin
      case (state_reg)
        LD_IDLE: begin
          if (start) begin
            n_reg      <= sample_num;
            rd_cnt_reg <= '0;
            busy_reg   <= 1'b1;
            // An empty load still passes through DRAIN so the done pulse
            // lands two cycles after start, like a pipe with nothing in it.
            if (sample_num == '0) begin
              state_reg <= LD_DRAIN;
            end else begin
              state_reg <= LD_READ;
              rd_en_reg <= 1'b1;
            end
          end
        end
        LD_READ: begin
          if (rd_cnt_reg == last_adr) begin
            rd_en_reg <= 1'b0;
            state_reg <= LD_DRAIN;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + ADDR_W'(1);
          end
        end
        LD_DRAIN: begin
          if (!pipe_inner_busy) begin
            state_reg <= LD_DONE;
            done_reg  <= 1'b1;
          end
        end
        LD_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= LD_IDLE;
        end
        default: state_reg <= LD_IDLE;
      endcase
    end
  end

  rd_lat_pipe #(
    .ADDR_W(ADDR_W),
    .DEPTH (RD_LAT)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (rd_en_reg),
    .in_adr    (rd_cnt_reg),
    .out_valid (pipe_valid),
    .out_adr   (pipe_adr),
    .inner_busy(pipe_inner_busy)
  );

  // Strobes are qualified by ce so a held state never repeats a read, write or done.
  assign mem_rd_en            = rd_en_reg & ce;
  assign mem_rd_adr           = rd_cnt_reg;
  assign cache_wr_en          = pipe_valid & ce;
  assign cache_wr_adr         = pipe_adr;
  assign cache_wr_data        = pipe_valid ? mem_rd_data : '0;
  assign busy                 = busy_reg;
  assign data_to_cache_loaded = done_reg & ce;

endmodule

// File: tb/tb_sample_cache_loader.sv
// Drives two loaders (read latency 1 and 3) with shared stimulus and checks
// reads, cache writes, done timing and busy against arithmetic expectations.
`timescale 1ns/1ps
module tb_sample_cache_loader;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] sample_num = '0;

  logic          rd_en_a, wr_en_a, busy_a, done_a;
  logic [AW-1:0] rd_adr_a, wr_adr_a;
  logic [DW-1:0] rd_data_a, wr_data_a;
  logic          rd_en_b, wr_en_b, busy_b, done_b;
  logic [AW-1:0] rd_adr_b, wr_adr_b;
  logic [DW-1:0] rd_data_b, wr_data_b;

  sample_cache_loader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .sample_num(sample_num),
    .mem_rd_en(rd_en_a), .mem_rd_adr(rd_adr_a), .mem_rd_data(rd_data_a),
    .cache_wr_en(wr_en_a), .cache_wr_adr(wr_adr_a), .cache_wr_data(wr_data_a),
    .busy(busy_a), .data_to_cache_loaded(done_a)
  );

  sample_cache_loader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .sample_num(sample_num),
    .mem_rd_en(rd_en_b), .mem_rd_adr(rd_adr_b), .mem_rd_data(rd_data_b),
    .cache_wr_en(wr_en_b), .cache_wr_adr(wr_adr_b), .cache_wr_data(wr_data_b),
    .busy(busy_b), .data_to_cache_loaded(done_b)
  );

  // Sample RAM models: shared contents, ce-gated registered read of depth 1 and 3.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] q1, q3_0, q3_1, q3_2;
  always @(posedge clk) begin
    if (ce) begin
      q1   <= ram[rd_adr_a];
      q3_0 <= ram[rd_adr_b];
      q3_1 <= q3_0;
      q3_2 <= q3_1;
    end
  end
  assign rd_data_a = q1;
  assign rd_data_b = q3_2;

  logic          rd_en_w [2], wr_en_w [2], done_w [2], busy_w [2];
  logic [AW-1:0] rd_adr_w [2], wr_adr_w [2];
  logic [DW-1:0] wr_data_w [2];
  assign rd_en_w[0] = rd_en_a;   assign rd_en_w[1] = rd_en_b;
  assign wr_en_w[0] = wr_en_a;   assign wr_en_w[1] = wr_en_b;
  assign done_w[0]  = done_a;    assign done_w[1]  = done_b;
  assign busy_w[0]  = busy_a;    assign busy_w[1]  = busy_b;
  assign rd_adr_w[0] = rd_adr_a; assign rd_adr_w[1] = rd_adr_b;
  assign wr_adr_w[0] = wr_adr_a; assign wr_adr_w[1] = wr_adr_b;
  assign wr_data_w[0] = wr_data_a; assign wr_data_w[1] = wr_data_b;

  // Monitor: act counts ce-high cycles; events are tagged with that index.
  int            act = 0;
  int            rd_n [2], wr_n [2], done_n [2], done_act [2], busy_n [2], stray [2];
  logic [AW-1:0] wr_adr_m  [2][DEPTH];
  logic [DW-1:0] wr_data_m [2][DEPTH];
  int            wr_act_m  [2][DEPTH];

  always @(negedge clk) begin
    if (ce) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_en_w[d]) rd_n[d]++;
        if (wr_en_w[d]) begin
          if (wr_n[d] < DEPTH) begin
            wr_adr_m[d][wr_n[d]]  = wr_adr_w[d];
            wr_data_m[d][wr_n[d]] = wr_data_w[d];
            wr_act_m[d][wr_n[d]]  = act;
          end
          wr_n[d]++;
        end
        if (done_w[d]) begin
          done_n[d]++;
          done_act[d] = act;
        end
        if (busy_w[d]) busy_n[d]++;
      end
      act++;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd_en_w[d] || wr_en_w[d] || done_w[d]) stray[d]++;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int start_act = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      rd_n[d] = 0; wr_n[d] = 0; done_n[d] = 0; done_act[d] = 0;
      busy_n[d] = 0; stray[d] = 0;
    end
  endtask

  task automatic fill_ram(input bit times3);
    for (int a = 0; a < DEPTH; a++) ram[a] = times3 ? DW'(a * 3) : DW'($urandom);
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d mem_rd_en", name, d), 32'(rd_en_w[d]), 0);
      check($sformatf("%s dut%0d mem_rd_adr", name, d), 32'(rd_adr_w[d]), 0);
      check($sformatf("%s dut%0d cache_wr_en", name, d), 32'(wr_en_w[d]), 0);
      check($sformatf("%s dut%0d cache_wr_adr", name, d), 32'(wr_adr_w[d]), 0);
      check($sformatf("%s dut%0d cache_wr_data", name, d), 32'(wr_data_w[d]), 0);
      check($sformatf("%s dut%0d busy", name, d), 32'(busy_w[d]), 0);
      check($sformatf("%s dut%0d done", name, d), 32'(done_w[d]), 0);
    end
  endtask

  // Expected behaviour of a load of n samples, optionally aborted by a reset
  // sampled at the end of cycle abort_cyc (start cycle = 0).
  task automatic check_results(input string name, input int n, input int abort_cyc);
    int lat, exp_rd, exp_wr, exp_done, exp_off, bad;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      if (abort_cyc > 0) begin
        exp_rd = (n < abort_cyc) ? n : abort_cyc;
        exp_wr = abort_cyc - lat;
        if (exp_wr > n) exp_wr = n;
        if (exp_wr < 0) exp_wr = 0;
        exp_done = 0;
        exp_off  = abort_cyc;
      end else begin
        exp_rd   = n;
        exp_wr   = n;
        exp_done = 1;
        exp_off  = (n == 0) ? 2 : n + lat + 1;
      end
      check($sformatf("%s lat%0d reads", name, lat), rd_n[d], exp_rd);
      check($sformatf("%s lat%0d writes", name, lat), wr_n[d], exp_wr);
      check($sformatf("%s lat%0d done pulses", name, lat), done_n[d], exp_done);
      if (exp_done > 0)
        check($sformatf("%s lat%0d done latency", name, lat), done_act[d] - start_act, exp_off);
      check($sformatf("%s lat%0d busy cycles", name, lat), busy_n[d], exp_off);
      check($sformatf("%s lat%0d strobes with ce low", name, lat), stray[d], 0);
      bad = -1;
      for (int i = 0; i < wr_n[d] && i < DEPTH; i++) begin
        if (bad < 0 && (wr_adr_m[d][i] !== AW'(i) || wr_data_m[d][i] !== ram[i] ||
                        wr_act_m[d][i] != start_act + lat + 1 + i))
          bad = i;
      end
      check($sformatf("%s lat%0d first bad write index", name, lat), bad, -1);
    end
  endtask

  task automatic do_load(input string name, input int n, input bit toggle_ce,
                         input bit repulse, input bit done_start);
    int k;
    bit d1;
    clear_mon();
    @(posedge clk); #1;
    ce = 1'b1; start = 1'b1; sample_num = AW'(n); start_act = act;
    k = 0;
    while (!(done_n[0] > 0 && done_n[1] > 0) && k < 20000) begin
      @(posedge clk); #1;
      k++;
      d1 = done_a;
      start = 1'b0;
      sample_num = AW'($urandom);
      ce = toggle_ce ? ((k % 4 == 1) || (k % 4 == 0)) : 1'b1;
      if (repulse && (k == 2 || k == 3)) begin
        start = 1'b1;
        sample_num = AW'(9);
      end
      if (done_start && d1) start = 1'b1;
    end
    check($sformatf("%s wait timeout", name), 32'(k >= 20000), 0);
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      start = 1'b0; ce = 1'b1;
    end
    check_results(name, n, 0);
    $display("load %s n=%0d ce_toggle=%0d: lat1 writes=%0d lat3 writes=%0d", name, n,
             toggle_ce, wr_n[0], wr_n[1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_ram(1'b1);
    rst = 1'b1; ce = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset state");
    rst = 1'b0;
    @(posedge clk); #1;

    do_load("n8_times3", 8, 1'b0, 1'b0, 1'b0);
    do_load("n0", 0, 1'b0, 1'b0, 1'b0);
    fill_ram(1'b0);
    do_load("n5_ce_toggle", 5, 1'b1, 1'b0, 1'b0);

    clear_mon();
    @(posedge clk); #1;
    ce = 1'b1; start = 1'b1; sample_num = AW'(16); start_act = act;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 6) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("after mid-load reset");
    repeat (20) begin
      @(posedge clk); #1;
    end
    check_results("reset_abort", 16, 6);
    $display("load reset_abort n=16: lat1 writes=%0d lat3 writes=%0d", wr_n[0], wr_n[1]);

    do_load("n4_after_reset", 4, 1'b0, 1'b0, 1'b0);
    do_load("n4_restart_ignored", 4, 1'b0, 1'b1, 1'b0);
    do_load("start_on_done", $urandom_range(3, 20), 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      fill_ram(1'b0);
      do_load($sformatf("random%0d", r), $urandom_range(1, 40), 1'($urandom_range(0, 1)),
              1'b0, 1'b0);
    end

    fill_ram(1'b0);
    do_load("n4095_max", 4095, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
